// File: rtl/unidade_controle.sv
// Game-flow control FSM (Moore): sequences plays and rounds, reports win/loss.
// Optional inactivity timeout is compiled in with `define TIMEOUT_EN.
module unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_igual,
  input  logic       fim_rodada,
  input  logic       fim_jogo,
  input  logic       inativo,
  output logic       zera_jogada,
  output logic       conta_jogada,
  output logic       zera_rodada,
  output logic       conta_rodada,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraInativo,
  output logic       contaInativo,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERROU      = 4'hE
  } estado_t;

  estado_t estado, proximo;
  logic    timeout_evt;

`ifdef TIMEOUT_EN
  assign timeout_evt = inativo;
`else
  // Masked to a constant so the timeout branch below is dead logic.
  assign timeout_evt = 1'b0 & inativo;
`endif

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     proximo = INICIO_RODADA;
      INICIO_RODADA:  proximo = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada_feita)     proximo = REGISTRA;
        else if (timeout_evt) proximo = FIM_TIMEOUT;
        else                  proximo = ESPERA_JOGADA;
      end
      REGISTRA:       proximo = COMPARACAO;
      COMPARACAO: begin
        if (!jogada_igual)             proximo = FIM_ERROU;
        else if (fim_rodada && fim_jogo) proximo = FIM_ACERTOU;
        else if (fim_rodada)           proximo = PROXIMA_RODADA;
        else                           proximo = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
      PROXIMA_RODADA: proximo = INICIO_RODADA;
      FIM_ACERTOU:    proximo = iniciar ? PREPARACAO : FIM_ACERTOU;
      FIM_ERROU:      proximo = iniciar ? PREPARACAO : FIM_ERROU;
`ifdef TIMEOUT_EN
      FIM_TIMEOUT:    proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
      default:        proximo = INICIAL;
    endcase
  end

  always_comb begin
    zera_jogada  = 1'b0;
    conta_jogada = 1'b0;
    zera_rodada  = 1'b0;
    conta_rodada = 1'b0;
    zeraR        = 1'b0;
    registraR    = 1'b0;
    zeraInativo  = 1'b0;
    contaInativo = 1'b0;
    pronto       = 1'b0;
    ganhou       = 1'b0;
    perdeu       = 1'b0;
    db_timeout   = 1'b0;
    case (estado)
      PREPARACAO: begin
        zera_jogada = 1'b1;
        zera_rodada = 1'b1;
        zeraR       = 1'b1;
        zeraInativo = 1'b1;
      end
      INICIO_RODADA: begin
        zera_jogada = 1'b1;
        zeraInativo = 1'b1;
      end
`ifdef TIMEOUT_EN
      ESPERA_JOGADA: contaInativo = 1'b1;
      FIM_TIMEOUT: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
`endif
      REGISTRA: begin
        registraR   = 1'b1;
        zeraInativo = 1'b1;
      end
      PROXIMA_JOGADA: conta_jogada = 1'b1;
      PROXIMA_RODADA: conta_rodada = 1'b1;
      FIM_ACERTOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: directed scenarios plus a randomized run against
// a table-driven game-rule model. Honours `define TIMEOUT_EN like the design.
module tb_unidade_controle;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada_feita, jogada_igual, fim_rodada, fim_jogo, inativo;
  logic       zera_jogada, conta_jogada, zera_rodada, conta_rodada, zeraR, registraR;
  logic       zeraInativo, contaInativo, pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;

  int vectors = 0;
  int miscompares = 0;
  int exp_state = 0;

`ifdef TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .jogada_igual(jogada_igual), .fim_rodada(fim_rodada), .fim_jogo(fim_jogo),
    .inativo(inativo), .zera_jogada(zera_jogada), .conta_jogada(conta_jogada),
    .zera_rodada(zera_rodada), .conta_rodada(conta_rodada), .zeraR(zeraR),
    .registraR(registraR), .zeraInativo(zeraInativo), .contaInativo(contaInativo),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .db_timeout(db_timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Output order: zj cj zr cr zR rR zI cI pronto ganhou perdeu timeout
  function automatic logic [11:0] outs();
    return {zera_jogada, conta_jogada, zera_rodada, conta_rodada, zeraR, registraR,
            zeraInativo, contaInativo, pronto, ganhou, perdeu, db_timeout};
  endfunction

  function automatic logic [11:0] exp_outs(input int s);
    case (s)
      1:  return 12'b1010_1010_0000;
      2:  return 12'b1000_0010_0000;
      3:  return TO ? 12'b0000_0001_0000 : 12'b0;
      4:  return 12'b0000_0110_0000;
      6:  return 12'b0100_0000_0000;
      7:  return 12'b0001_0000_0000;
      10: return 12'b0000_0000_1100;
      13: return TO ? 12'b0000_0000_1011 : 12'b0;
      14: return 12'b0000_0000_1010;
      default: return 12'b0;
    endcase
  endfunction

  // Game rules as a state-code transition table.
  function automatic int model_next(input int s);
    if (reset) return 0;
    case (s)
      0:  return iniciar ? 1 : 0;
      1:  return 2;
      2:  return 3;
      3:  return jogada_feita ? 4 : ((TO && inativo) ? 13 : 3);
      4:  return 5;
      5:  return !jogada_igual ? 14 : (fim_rodada ? (fim_jogo ? 10 : 7) : 6);
      6:  return 3;
      7:  return 2;
      10, 14: return iniciar ? 1 : s;
      13: return TO ? (iniciar ? 1 : 13) : 0;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    exp_state = model_next(exp_state);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = $urandom_range(0, 1); jogada_feita = $urandom_range(0, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (db_estado !== 4'h0 || outs() !== 12'b0) begin
        miscompares++;
        $display("FAIL reset: estado %0h outs %b, required 0 / 0", db_estado, outs());
      end
    end
    reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0;
    tick();
    vectors++;
    if (db_estado !== 4'h0 || outs() !== 12'b0) begin
      miscompares++;
      $display("FAIL idle: estado %0h outs %b, required 0 / 0", db_estado, outs());
    end
  endtask

  task automatic test_start();
    int seq[3] = '{1, 2, 3};
    iniciar = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      iniciar = 1'b0;
      vectors++;
      if (db_estado !== 4'(seq[i]) || outs() !== exp_outs(seq[i]) || zera_rodada !== (i == 0)) begin
        miscompares++;
        $display("FAIL start[%0d]: estado %0h outs %b, required %0h / %b", i, db_estado, outs(), seq[i], exp_outs(seq[i]));
      end
    end
  endtask

  task automatic test_mid_round();
    int seq[4] = '{4, 5, 6, 3};
    int n_reg = 0, n_cj = 0;
    jogada_feita = 1'b1; jogada_igual = 1'b1; fim_rodada = 1'b0; fim_jogo = $urandom_range(0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      jogada_feita = 1'b0;
      n_reg += int'(registraR);
      n_cj  += int'(conta_jogada);
      vectors++;
      if (db_estado !== 4'(seq[i]) || outs() !== exp_outs(seq[i])) begin
        miscompares++;
        $display("FAIL mid_round[%0d]: estado %0h outs %b, required %0h / %b", i, db_estado, outs(), seq[i], exp_outs(seq[i]));
      end
    end
    vectors++;
    if (n_reg != 1 || n_cj != 1) begin
      miscompares++;
      $display("FAIL pulse_width: registraR %0d cycles, conta_jogada %0d cycles, required 1 / 1", n_reg, n_cj);
    end
  endtask

  task automatic test_round_end();
    int seq[5] = '{4, 5, 7, 2, 3};
    int n_cr = 0;
    jogada_feita = 1'b1; jogada_igual = 1'b1; fim_rodada = 1'b1; fim_jogo = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      jogada_feita = 1'b0;
      n_cr += int'(conta_rodada);
      vectors++;
      if (db_estado !== 4'(seq[i]) || outs() !== exp_outs(seq[i])) begin
        miscompares++;
        $display("FAIL round_end[%0d]: estado %0h outs %b, required %0h / %b", i, db_estado, outs(), seq[i], exp_outs(seq[i]));
      end
    end
    vectors++;
    if (n_cr != 1) begin
      miscompares++;
      $display("FAIL conta_rodada: high %0d cycles, required 1", n_cr);
    end
  endtask

  task automatic test_win();
    jogada_feita = 1'b1; jogada_igual = 1'b1; fim_rodada = 1'b1; fim_jogo = 1'b1;
    tick(); jogada_feita = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (db_estado !== 4'hA || outs() !== 12'b0000_0000_1100) begin
        miscompares++;
        $display("FAIL win_hold[%0d]: estado %0h outs %b, required a / 000000001100", i, db_estado, outs());
      end
      jogada_feita = $urandom_range(0, 1); jogada_igual = $urandom_range(0, 1); inativo = $urandom_range(0, 1);
      tick();
    end
    jogada_feita = 1'b0; inativo = 1'b0;
  endtask

  task automatic test_error_restart();
    iniciar = 1'b1;
    tick(); iniciar = 1'b0;
    tick(); tick();
    vectors++;
    if (db_estado !== 4'h3) begin
      miscompares++;
      $display("FAIL restart_win: estado %0h, required 3", db_estado);
    end
    jogada_feita = 1'b1; jogada_igual = 1'b0; fim_rodada = $urandom_range(0, 1); fim_jogo = $urandom_range(0, 1);
    tick(); jogada_feita = 1'b0;
    tick(); tick();
    vectors++;
    if (db_estado !== 4'hE || outs() !== 12'b0000_0000_1010) begin
      miscompares++;
      $display("FAIL error: estado %0h outs %b, required e / 000000001010", db_estado, outs());
    end
    iniciar = 1'b1;
    tick(); iniciar = 1'b0;
    vectors++;
    if (db_estado !== 4'h1) begin
      miscompares++;
      $display("FAIL restart_err: estado %0h, required 1", db_estado);
    end
    tick(); tick();
    jogada_igual = 1'b1;
  endtask

  task automatic test_timeout();
`ifdef TIMEOUT_EN
    inativo = 1'b1;
    tick(); inativo = 1'b0;
    vectors++;
    if (db_estado !== 4'hD || outs() !== 12'b0000_0000_1011) begin
      miscompares++;
      $display("FAIL timeout: estado %0h outs %b, required d / 000000001011", db_estado, outs());
    end
    iniciar = 1'b1;
    tick(); iniciar = 1'b0;
    tick(); tick();
    jogada_feita = 1'b1; inativo = 1'b1;
    tick(); jogada_feita = 1'b0; inativo = 1'b0;
    vectors++;
    if (db_estado !== 4'h4) begin
      miscompares++;
      $display("FAIL play_beats_timeout: estado %0h, required 4", db_estado);
    end
    jogada_igual = 1'b1; fim_rodada = 1'b0;
    tick(); tick(); tick();
`else
    inativo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (db_estado !== 4'h3 || contaInativo !== 1'b0 || db_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_off[%0d]: estado %0h cI %b to %b, required 3 / 0 / 0", i, db_estado, contaInativo, db_timeout);
      end
    end
    inativo = 1'b0;
`endif
  endtask

  task automatic test_mid_reset();
    jogada_feita = 1'b1;
    tick(); jogada_feita = 1'b0;
    tick();
    vectors++;
    if (db_estado !== 4'h5) begin
      miscompares++;
      $display("FAIL reach_cmp: estado %0h, required 5", db_estado);
    end
    reset = 1'b1; jogada_igual = $urandom_range(0, 1); fim_rodada = $urandom_range(0, 1);
    tick(); reset = 1'b0;
    vectors++;
    if (db_estado !== 4'h0 || outs() !== 12'b0) begin
      miscompares++;
      $display("FAIL mid_reset: estado %0h outs %b, required 0 / 0", db_estado, outs());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      iniciar      = ($urandom_range(0, 7) == 0);
      jogada_feita = ($urandom_range(0, 2) == 0);
      jogada_igual = ($urandom_range(0, 7) != 0);
      fim_rodada   = $urandom_range(0, 1);
      fim_jogo     = ($urandom_range(0, 3) == 0);
      inativo      = ($urandom_range(0, 5) == 0);
      tick();
      vectors++;
      if (db_estado !== 4'(exp_state) || outs() !== exp_outs(exp_state)) begin
        miscompares++;
        $display("FAIL random[%0d]: estado %0h outs %b, required %0h / %b", i, db_estado, outs(), exp_state, exp_outs(exp_state));
      end
    end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; jogada_feita = 1'b0; jogada_igual = 1'b0;
    fim_rodada = 1'b0; fim_jogo = 1'b0; inativo = 1'b0;
    test_reset();
    test_start();
    test_mid_round();
    test_round_end();
    test_win();
    test_error_restart();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
